reduce_stream: RTL and testbench

REDUCE_STREAM -- requirements
Module: reduce_stream

---
 rtl/reduce_stream.sv | 132 +++++++++++++
 tb/tb_reduce_stream.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/reduce_stream.sv
// Frame-based bit reducer: each beat reduces every STRIDE-th bit of data_in, beats are
// combined across a frame, and a one-bit result plus beat count is held until consumed.
module reduce_stream #(
  parameter int LEN    = 8,
  parameter int STRIDE = 2,
  parameter int BEATS  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [1:0]                       op_sel,
  input  logic [LEN-1:0]                   data_in,
  input  logic                             in_valid,
  input  logic                             in_last,
  output logic                             in_ready,
  output logic                             reduced_out,
  output logic [$clog2(BEATS+1)-1:0]       out_beats,
  output logic                             out_valid,
  input  logic                             out_ready
);

  localparam int CW = ($clog2(BEATS+1) > 1) ? $clog2(BEATS+1) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS-1);

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic          res_q, res_d;
  logic [CW-1:0] beats_q, beats_d;

  logic       sel_and, sel_or, sel_xor;
  logic       first_beat, accept, last_beat;
  logic [1:0] op_eff;
  logic       beat_val, acc_new, frame_res;

  always_comb begin
    sel_and = 1'b1;
    sel_or  = 1'b0;
    sel_xor = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      if (i % STRIDE == 0) begin
        sel_and = sel_and & data_in[i];
        sel_or  = sel_or  | data_in[i];
        sel_xor = sel_xor ^ data_in[i];
      end
    end
  end

  // Handshake: a beat transfers on an edge with in_valid && in_ready (in_ready=1 only in ACC);
  // a result transfers on an edge with out_valid && out_ready (out_valid=1 only in HOLD).
  assign in_ready    = (state_q == ST_ACC);
  assign out_valid   = (state_q == ST_HOLD);
  assign reduced_out = res_q;
  assign out_beats   = beats_q;

  assign first_beat = (cnt_q == '0);
  assign accept     = in_valid && in_ready;
  assign last_beat  = in_last || (cnt_q == LAST_CNT);
  assign op_eff     = first_beat ? op_sel : op_q;

  always_comb begin
    case (op_eff)
      2'b00:   beat_val = sel_and;
      2'b01:   beat_val = sel_or;
      default: beat_val = sel_xor;
    endcase
    if (first_beat) begin
      acc_new = beat_val;
    end else begin
      case (op_eff)
        2'b00:   acc_new = acc_q & beat_val;
        2'b01:   acc_new = acc_q | beat_val;
        default: acc_new = acc_q ^ beat_val;
      endcase
    end
    // XNOR accumulates as XOR and inverts only once, at the end of the frame.
    frame_res = (op_eff == 2'b11) ? ~acc_new : acc_new;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    res_d   = res_q;
    beats_d = beats_q;
    case (state_q)
      ST_ACC: begin
        if (accept) begin
          op_d = op_eff;
          if (last_beat) begin
            res_d   = frame_res;
            beats_d = cnt_q + 1'b1;
            state_d = ST_HOLD;
          end else begin
            acc_d = acc_new;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        if (out_ready) begin
          state_d = ST_ACC;
          acc_d   = 1'b0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      op_q    <= 2'b00;
      res_q   <= 1'b0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
      beats_q <= beats_d;
    end
  end

endmodule

// File: tb/tb_reduce_stream.sv
// Directed bench for reduce_stream (LEN=8, STRIDE=2, BEATS=4): vector table of whole
// frames plus hand-written sequences for backpressure, reset mid-frame and back-to-back.
module tb_reduce_stream;

  localparam int LEN   = 8;
  localparam int BEATS = 4;
  localparam int CW    = $clog2(BEATS+1);
  localparam int W     = 1 + CW;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    op_sel;
  logic [LEN-1:0] data_in;
  logic          in_valid, in_last, in_ready;
  logic          reduced_out;
  logic [CW-1:0] out_beats;
  logic          out_valid, out_ready;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [1:0]         op0;
    logic [1:0]         opn;
    logic [3:0][7:0]    d;
    int                 n;
    bit                 use_last;
    logic               exp_red;
    int                 exp_beats;
  } vec_t;

  vec_t vecs[14];

  reduce_stream #(.LEN(LEN), .STRIDE(2), .BEATS(BEATS)) dut (
    .clk(clk), .rst(rst), .op_sel(op_sel), .data_in(data_in), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .reduced_out(reduced_out),
    .out_beats(out_beats), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op0, input logic [1:0] opn,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] d3,
                              input int n, input bit use_last,
                              input logic red, input int bts);
    vec_t v;
    v.op0 = op0; v.opn = opn;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.n = n; v.use_last = use_last; v.exp_red = red; v.exp_beats = bts;
    return v;
  endfunction

  task automatic drive_beat(input logic [1:0] op, input logic [7:0] d, input logic last);
    op_sel = op; data_in = d; in_last = last; in_valid = 1'b1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_last = 1'b0; data_in = '0; op_sel = 2'b00;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      drive_beat((i == 0) ? v.op0 : v.opn, v.d[i], v.use_last && (i == v.n - 1));
      check($sformatf("v%0d_in_ready_b%0d", idx, i), in_ready, 1);
      check($sformatf("v%0d_no_early_valid_b%0d", idx, i), out_valid, 0);
      tick();
    end
    idle();
    check($sformatf("v%0d_out_valid", idx), out_valid, 1);
    check($sformatf("v%0d_reduced", idx), reduced_out, v.exp_red);
    check($sformatf("v%0d_beats", idx), out_beats, v.exp_beats);
    check($sformatf("v%0d_hold_in_ready", idx), in_ready, 0);
    tick();
    check($sformatf("v%0d_released", idx), out_valid, 0);
  endtask

  initial begin
    logic [7:0] b2b_d[12];
    logic [1:0] b2b_op[12];
    int idx, cycles, got, last_cyc, nres;
    logic [W-1:0] e;

    rst = 1'b1; out_ready = 1'b1;
    idle();

    vecs[0]  = mk(2'b00, 2'b00, 8'h55, 8'h55, 8'h55, 8'h55, 4, 0, 1'b1, 4);
    vecs[1]  = mk(2'b01, 2'b01, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 4, 0, 1'b0, 4);
    vecs[2]  = mk(2'b10, 2'b10, 8'h01, 8'h05, 8'h00, 8'h00, 2, 1, 1'b1, 2);
    vecs[3]  = mk(2'b01, 2'b00, 8'h01, 8'hA0, 8'hA0, 8'hA0, 4, 0, 1'b1, 4);
    vecs[4]  = mk(2'b11, 2'b11, 8'h55, 8'h55, 8'h55, 8'h55, 4, 0, 1'b1, 4);
    vecs[5]  = mk(2'b00, 2'b00, 8'h55, 8'h00, 8'h00, 8'h00, 1, 1, 1'b1, 1);
    vecs[6]  = mk(2'b11, 2'b11, 8'h01, 8'h00, 8'h00, 8'h00, 1, 1, 1'b0, 1);
    vecs[7]  = mk(2'b10, 2'b10, 8'h03, 8'h03, 8'h03, 8'h00, 3, 1, 1'b1, 3);
    vecs[8]  = mk(2'b00, 2'b00, 8'h55, 8'h54, 8'h00, 8'h00, 2, 1, 1'b0, 2);
    vecs[9]  = mk(2'b01, 2'b01, 8'hAA, 8'hAA, 8'h10, 8'hAA, 4, 0, 1'b1, 4);
    vecs[10] = mk(2'b11, 2'b11, 8'h01, 8'h04, 8'h00, 8'h00, 2, 1, 1'b1, 2);
    vecs[11] = mk(2'b11, 2'b11, 8'h01, 8'h00, 8'h00, 8'h00, 2, 1, 1'b0, 2);
    vecs[12] = mk(2'b00, 2'b00, 8'hFF, 8'hFF, 8'hFF, 8'hAA, 4, 0, 1'b0, 4);
    vecs[13] = mk(2'b01, 2'b01, 8'h00, 8'h00, 8'h00, 8'h40, 4, 0, 1'b1, 4);

    // Reset state observed while rst is still asserted.
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_reduced", reduced_out, 0);
    check("rst_beats", out_beats, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Backpressure: hold the result for 5 cycles while junk beats are offered.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_beat(2'b00, 8'h55, 1'b0);
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      drive_beat(2'b00, 8'h00, 1'b0);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_reduced", reduced_out, 1);
      check("bp_beats", out_beats, 4);
      tick();
    end
    check("bp_still_hold", out_valid, 1);
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    drive_beat(2'b00, 8'h00, 1'b1);
    tick();
    idle();
    check("bp_next_valid", out_valid, 1);
    check("bp_next_reduced", reduced_out, 0);
    check("bp_next_beats", out_beats, 1);
    tick();

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 2; i++) begin
      drive_beat(2'b00, 8'h00, 1'b0);
      tick();
    end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_out_valid", out_valid, 0);
    check("mr_in_ready", in_ready, 1);
    check("mr_beats", out_beats, 0);
    nres = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 4) drive_beat(2'b11, 8'h55, 1'b0);
      else idle();
      if (out_valid) begin
        nres++;
        check("mr_reduced", reduced_out, 1);
        check("mr_beats_res", out_beats, 4);
      end
      tick();
    end
    check("mr_result_count", nres, 1);

    // Back-to-back: in_valid held high across three 4-beat frames.
    for (int i = 0; i < 12; i++) begin
      if (i < 4)      begin b2b_d[i] = 8'h55; b2b_op[i] = 2'b00; end
      else if (i < 8) begin b2b_d[i] = 8'hAA; b2b_op[i] = 2'b01; end
      else            begin b2b_d[i] = (i == 11) ? 8'h00 : 8'h01; b2b_op[i] = 2'b10; end
    end
    exp_q.push_back({1'b1, 3'd4});
    exp_q.push_back({1'b0, 3'd4});
    exp_q.push_back({1'b1, 3'd4});
    idx = 0; cycles = 0; got = 0; last_cyc = -1;
    while (got < 3 && cycles < 40) begin
      logic acc;
      if (idx < 12) drive_beat(b2b_op[idx], b2b_d[idx], 1'b0);
      else idle();
      acc = in_valid && in_ready;
      if (out_valid) begin
        e = exp_q.pop_front();
        check("b2b_result", {reduced_out, out_beats}, e);
        got++;
        last_cyc = cycles;
      end
      tick();
      if (acc) idx++;
      cycles++;
    end
    idle();
    check("b2b_results", got, 3);
    check("b2b_beats_used", idx, 12);
    check("b2b_last_result_cycle", last_cyc, 14);
    check("b2b_queue_empty", exp_q.size(), 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
